pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 129 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } sup_state_t;

  // Counter must hold (largest cycle parameter - 1); never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status bits; synchronous active-high reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock for a stable period, then releases the
// downstream synchronous reset; retries on timeout and counts lock losses.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 4,
  parameter int unsigned LOSS_CNT_W          = 8
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               lock_fail,
  output logic [LOSS_CNT_W-1:0]              loss_count,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int unsigned CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  sup_state_t              state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [RETRY_W-1:0]      retry_next;
  logic [LOSS_CNT_W-1:0]   loss_next;
  logic                    lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      retry_count <= retry_next;
      loss_count  <= loss_next;
      // Outputs decode the state being entered so they line up with it.
      pll_rst     <= (state_next == PLL_RST) || (state_next == FAIL);
      sys_rst     <= (state_next != RUN);
      ready       <= (state_next == RUN);
      lock_fail   <= (state_next == FAIL);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    retry_next = retry_count;
    loss_next  = loss_count;

    if (relock_req) begin
      state_next = PLL_RST;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == PULSE_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        WAIT_LOCK: begin
          // A lock arriving on the timeout cycle takes precedence.
          if (lock_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_next = '0;
            if (retry_count < RETRY_MAX) begin
              retry_next = retry_count + 1'b1;
              state_next = PLL_RST;
            end else begin
              state_next = FAIL;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end
        RUN: begin
          cnt_next = '0;
          if (!lock_s) begin
            state_next = PLL_RST;
            retry_next = '0;
            if (loss_count != '1) loss_next = loss_count + 1'b1;
          end
        end
        FAIL: begin
          cnt_next = '0;
        end
        default: begin
          state_next = PLL_RST;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 100;
  localparam int ST = 16;
  localparam int MR = 2;
  localparam int LW = 8;
  localparam int LOSS_MAX = (1 << LW) - 1;

  localparam int SEL_SYS_RST = 0;
  localparam int SEL_READY   = 1;
  localparam int SEL_PLL_RST = 2;
  localparam int SEL_FAIL    = 3;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst, sys_rst, ready, lock_fail;
  logic [LW-1:0] loss_count;
  logic [$clog2(MR+1)-1:0] retry_count;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .STABLE_CYCLES       (ST),
    .MAX_RETRIES         (MR),
    .LOSS_CNT_W          (LW)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .lock_fail   (lock_fail),
    .loss_count  (loss_count),
    .retry_count (retry_count)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: which phase the supervisor is in and how long it has been there.
  typedef enum int {M_PULSE, M_AWAIT, M_QUALIFY, M_RUN, M_FAILED} mphase_t;
  mphase_t ph = M_PULSE;
  int  t = 0;
  int  retries = 0;
  int  losses = 0;
  bit  s1 = 1'b0, s2 = 1'b0;

  task automatic enter(input mphase_t p);
    ph = p;
    t  = 0;
  endtask

  always @(posedge refclk) begin
    bit seen;
    seen = s2;
    if (rst) begin
      enter(M_PULSE);
      retries = 0;
      losses  = 0;
      s1 = 1'b0;
      s2 = 1'b0;
    end else begin
      if (relock_req) begin
        enter(M_PULSE);
        retries = 0;
      end else begin
        case (ph)
          M_PULSE:   if (t == RP - 1) enter(M_AWAIT); else t++;
          M_AWAIT: begin
            if (seen) enter(M_QUALIFY);
            else if (t == TO - 1) begin
              if (retries < MR) begin retries++; enter(M_PULSE); end
              else enter(M_FAILED);
            end else t++;
          end
          M_QUALIFY: begin
            if (!seen) enter(M_AWAIT);
            else if (t == ST - 1) enter(M_RUN);
            else t++;
          end
          M_RUN: begin
            if (!seen) begin
              losses  = (losses < LOSS_MAX) ? losses + 1 : LOSS_MAX;
              retries = 0;
              enter(M_PULSE);
            end
          end
          default: ;
        endcase
      end
      s2 = s1;
      s1 = pll_locked;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    cmp(name, act, exp);
  endtask

  always @(negedge refclk) begin
    if (armed) begin
      vectors++;
      cmp("pll_rst",     int'(pll_rst),     int'(ph == M_PULSE || ph == M_FAILED));
      cmp("sys_rst",     int'(sys_rst),     int'(ph != M_RUN));
      cmp("ready",       int'(ready),       int'(ph == M_RUN));
      cmp("lock_fail",   int'(lock_fail),   int'(ph == M_FAILED));
      cmp("loss_count",  int'(loss_count),  losses);
      cmp("retry_count", int'(retry_count), retries);
    end
  end

  task automatic tick();
    @(posedge refclk);
    #2;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_SYS_RST: return sys_rst;
      SEL_READY:   return ready;
      SEL_PLL_RST: return pll_rst;
      default:     return lock_fail;
    endcase
  endfunction

  // Ticks until the selected output reaches val; n is the number of clock edges taken.
  task automatic wait_until(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      tick();
      n++;
    end
    if (sig(sel) !== val) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_sel%0d: got %0b after %0d cycles, expected %0b", sel, sig(sel), n, val);
    end
  endtask

  initial begin
    int n;
    int prev, run, pulses, good_pulses, good_waits, steps;

    // Reset values
    repeat (3) tick();
    armed = 1'b1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_ready", ready, 0);
    check("rst_counts", int'(loss_count) + int'(retry_count) + int'(lock_fail), 0);
    rst = 1'b0;

    // Release after reset
    wait_until(SEL_PLL_RST, 1'b0, 50, n);
    check("first_pulse_width", n, 4);
    repeat (20) tick();
    pll_locked = 1'b1;
    wait_until(SEL_SYS_RST, 1'b0, 100, n);
    // 2 synchronizer edges, 1 edge accepting lock, 16 stable edges
    check("release_latency", n, 19);
    check("release_ready", ready, 1);
    check("release_retry", retry_count, 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    wait_until(SEL_SYS_RST, 1'b1, 20, n);
    check("loss_latency", n, 3);
    check("loss_ready", ready, 0);
    check("loss_count_1", loss_count, 1);
    pll_locked = 1'b1;
    wait_until(SEL_READY, 1'b1, 200, n);
    check("rerun_retry", retry_count, 0);

    // Drive loss_count to saturation
    for (int i = 0; i < 254; i++) begin
      pll_locked = 1'b0;
      wait_until(SEL_SYS_RST, 1'b1, 20, n);
      pll_locked = 1'b1;
      wait_until(SEL_READY, 1'b1, 200, n);
    end
    check("loss_count_255", loss_count, 255);
    pll_locked = 1'b0;
    wait_until(SEL_SYS_RST, 1'b1, 20, n);
    check("loss_saturated", loss_count, 255);
    pll_locked = 1'b1;
    wait_until(SEL_READY, 1'b1, 200, n);

    // relock_req from RUN is not a loss; then lock never arrives
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_from_run_loss", loss_count, 255);
    check("relock_from_run_pll_rst", pll_rst, 1);
    prev = pll_rst; run = 1; pulses = 0; good_pulses = 0; good_waits = 0; steps = 0;
    while (!lock_fail && steps < 1000) begin
      tick();
      steps++;
      if (int'(pll_rst) == prev) run++;
      else begin
        if (prev == 1) begin pulses++; if (run == 4) good_pulses++; end
        else if (run == 100) good_waits++;
        prev = pll_rst;
        run = 1;
      end
    end
    check("nolock_pulses", pulses, 3);
    check("nolock_pulse_widths", good_pulses, 3);
    check("nolock_waits", good_waits, 3);
    check("nolock_fail", lock_fail, 1);
    check("nolock_retry", retry_count, 2);
    repeat (5) tick();
    check("fail_holds_pll_rst", pll_rst, 1);
    check("fail_sticky", lock_fail, 1);

    // Recovery from FAIL
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("recover_fail_clear", lock_fail, 0);
    check("recover_pll_rst", pll_rst, 1);
    check("recover_loss_kept", loss_count, 255);
    // Line relock_req up with the first WAIT_LOCK timeout edge
    repeat (103) tick();
    check("pre_timeout_waiting", pll_rst, 0);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_vs_timeout_retry", retry_count, 0);
    check("relock_vs_timeout_pll_rst", pll_rst, 1);

    // Lock glitch during STABLE
    wait_until(SEL_PLL_RST, 1'b0, 20, n);
    pll_locked = 1'b1;
    repeat (10) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_until(SEL_SYS_RST, 1'b0, 100, n);
    check("glitch_release_latency", n, 19);
    check("glitch_retry", retry_count, 0);

    // Mid-operation reset while in STABLE
    pll_locked = 1'b0;
    wait_until(SEL_SYS_RST, 1'b1, 20, n);
    wait_until(SEL_PLL_RST, 1'b0, 20, n);
    pll_locked = 1'b1;
    repeat (8) tick();
    check("in_stable_sys_rst", sys_rst, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pll_rst", pll_rst, 1);
    check("midrst_sys_rst", sys_rst, 1);
    check("midrst_loss", loss_count, 0);
    check("midrst_retry", retry_count, 0);
    wait_until(SEL_READY, 1'b1, 200, n);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
